// File: rtl/joy_shifter_md_emu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | joy_shifter_md_emu                                                    |
// | Far-end model of the 16-bit joystick shifter with two DB9 pads.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module joy_shifter_md_emu #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 75000,
  parameter int P1_POS         = 2,
  parameter int P2_POS         = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_clk,
  input  logic        joy_load_n,
  input  logic        joy_select,
  input  logic [11:0] joy1_i,
  input  logic [11:0] joy2_i,
  input  logic [1:0]  pad_type,
  output logic        joy_data,
  output logic [1:0]  md_phase
);

  // Packed as {select, load_n, clk}
  localparam logic [2:0]  c_SYNC_IDLE = 3'b110;
  localparam logic [16:0] c_TIMEOUT   = 17'(TIMEOUT_CYCLES);

  logic [2:0]  r_sync [SYNC_STAGES];
  logic [2:0]  r_prev;
  logic [2:0]  w_cur;
  logic        w_clk_rise;
  logic        w_load;
  logic        w_sel;
  logic        w_sel_rise;
  logic        w_sel_edge;
  logic [1:0]  r_phase;
  logic [16:0] r_idle;
  logic [15:0] r_sreg;
  logic [15:0] w_frame;
  logic [5:0]  w_lines1;
  logic [5:0]  w_lines2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= c_SYNC_IDLE;
      r_prev <= c_SYNC_IDLE;
    end else begin
      r_sync[0] <= {joy_select, joy_load_n, joy_clk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_cur;
    end
  end

  assign w_cur      = r_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_cur[0] & ~r_prev[0];
  assign w_load     = ~w_cur[1];
  assign w_sel      = w_cur[2];
  assign w_sel_rise = w_sel & ~r_prev[2];
  assign w_sel_edge = w_sel ^ r_prev[2];

  // A select edge always takes priority over the idle timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 2'd0;
      r_idle  <= 17'd0;
    end else if (w_sel_edge) begin
      r_idle <= 17'd0;
      if (w_sel_rise) r_phase <= r_phase + 2'd1;
    end else if (r_idle == c_TIMEOUT) begin
      r_phase <= 2'd0;
    end else begin
      r_idle <= r_idle + 17'd1;
    end
  end

  // Returns {U, D, L, R, F1, F2} for one pad
  function automatic logic [5:0] pad_lines(input logic [11:0] b, input logic md,
                                           input logic s, input logic [1:0] ph);
    logic [5:0] l;
    if (!md || (s && ph != 2'd3)) l = {b[0], b[1], b[2], b[3], b[4], b[5]};
    else if (s)                   l = {b[8], b[9], b[10], b[11], 2'b11};
    else if (ph == 2'd2)          l = {4'b0000, b[7], b[6]};
    else                          l = {b[0], b[1], 2'b00, b[7], b[6]};
    return l;
  endfunction

  assign w_lines1 = pad_lines(joy1_i, pad_type[0], w_sel, r_phase);
  assign w_lines2 = pad_lines(joy2_i, pad_type[1], w_sel, r_phase);

  // Frame order from the base position upward: F1, F2, R, L, D, U
  always_comb begin
    w_frame = '1;
    w_frame[P1_POS +: 6] = {w_lines1[5:2], w_lines1[0], w_lines1[1]};
    w_frame[P2_POS +: 6] = {w_lines2[5:2], w_lines2[0], w_lines2[1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_sreg <= '1;
    else if (w_load)     r_sreg <= w_frame;
    else if (w_clk_rise) r_sreg <= {1'b1, r_sreg[15:1]};
  end

  assign joy_data = r_sreg[0];
  assign md_phase = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_joy_shifter_md_emu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_joy_shifter_md_emu                                                 |
// | Randomised bench with a pad-level reference model and serial reader.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_joy_shifter_md_emu;

  localparam int T  = 1000;
  localparam int P1 = 2;
  localparam int P2 = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_clk = 1'b0;
  logic        joy_load_n = 1'b1;
  logic        joy_select = 1'b1;
  logic [11:0] joy1_i = 12'hFFF;
  logic [11:0] joy2_i = 12'hFFF;
  logic [1:0]  pad_type = 2'b00;
  logic        joy_data;
  logic [1:0]  md_phase;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_sel = 0;
  int m_phase = 0;

  logic [15:0] f, exp_f;
  logic [11:0] d1, d2;
  logic        six;

  joy_shifter_md_emu #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(T), .P1_POS(P1), .P2_POS(P2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load_n(joy_load_n),
    .joy_select(joy_select), .joy1_i(joy1_i), .joy2_i(joy2_i),
    .pad_type(pad_type), .joy_data(joy_data), .md_phase(md_phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit expired();
    return (cyc - last_sel) > T + 10;
  endfunction

  function automatic int eff_phase();
    return expired() ? 0 : m_phase;
  endfunction

  // Keep clear of the window where the DUT timeout is about to fire
  task automatic guard();
    int g;
    g = cyc - last_sel;
    if (g > T - 300 && g <= T + 20) step(350);
  endtask

  task automatic sel_set(input logic v);
    if (v !== joy_select) begin
      guard();
      if (expired()) m_phase = 0;
      if (v) m_phase = (m_phase + 1) % 4;
      joy_select = v;
      last_sel = cyc;
      step(6);
    end
  endtask

  task automatic read_frame(output logic [15:0] fr, input bit clk_in_load);
    joy_load_n = 1'b0;
    step(6);
    if (clk_in_load) begin
      joy_clk = 1'b1; step(6); joy_clk = 1'b0; step(6);
    end
    joy_load_n = 1'b1;
    step(6);
    for (int i = 0; i < 16; i++) begin
      fr[i] = joy_data;
      joy_clk = 1'b1; step(6);
      joy_clk = 1'b0; step(6);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [11:0] j1, input logic [11:0] j2,
                                              input logic [1:0] pt, input logic s, input int ph);
    logic [15:0] fr;
    logic [11:0] b;
    int pos;
    logic u, d, l, r, f1, f2;
    fr = '1;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? j1 : j2;
      pos = (p == 0) ? P1 : P2;
      u = b[0]; d = b[1]; l = b[2]; r = b[3]; f1 = b[4]; f2 = b[5];
      if (pt[p]) begin
        if (s && ph == 3) begin
          u = b[8]; d = b[9]; l = b[10]; r = b[11]; f1 = 1'b1; f2 = 1'b1;
        end else if (!s) begin
          f1 = b[7]; f2 = b[6]; l = 1'b0; r = 1'b0;
          if (ph == 2) begin u = 1'b0; d = 1'b0; end
        end
      end
      fr[pos] = f1; fr[pos+1] = f2; fr[pos+2] = r;
      fr[pos+3] = l; fr[pos+4] = d; fr[pos+5] = u;
    end
    return fr;
  endfunction

  // Direction/button group of a pad as {C, B, R, L, D, U}
  function automatic logic [5:0] dec6(input logic [15:0] fr, input int pos);
    return {fr[pos+1], fr[pos], fr[pos+2], fr[pos+3], fr[pos+4], fr[pos+5]};
  endfunction

  initial begin
    step(2);
    check("rst_data", 16'(joy_data), 16'h1);
    check("rst_phase", 16'(md_phase), 16'h0);
    reset_n = 1'b1;
    last_sel = cyc;
    m_phase = 0;
    step(4);

    // Passive pad, Up pressed
    pad_type = 2'b00; joy1_i = 12'hFFE;
    read_frame(f, 1'b0);
    check("up_frame", f, 16'hFF7F);
    check("tail_ones", 16'(joy_data), 16'h1);
    joy_clk = 1'b1; step(6); joy_clk = 1'b0; step(6);
    check("tail_extra", 16'(joy_data), 16'h1);

    // MD pad, select low, phase 0, Start pressed
    pad_type = 2'b01; joy1_i = 12'hF7F;
    sel_set(1'b0);
    read_frame(f, 1'b0);
    check("md_start", f, 16'hFFCB);

    // Three rising edges to phase 3, X pressed
    sel_set(1'b1); sel_set(1'b0); sel_set(1'b1); sel_set(1'b0); sel_set(1'b1);
    check("phase3", 16'(md_phase), 16'h3);
    joy1_i = 12'hBFF;
    read_frame(f, 1'b0);
    check("md_x", f, 16'hFFDF);

    // Reset mid-shift while Up bit is on the line
    pad_type = 2'b00; joy1_i = 12'hFFE;
    joy_load_n = 1'b0; step(6); joy_load_n = 1'b1; step(6);
    for (int i = 0; i < 7; i++) begin
      joy_clk = 1'b1; step(6); joy_clk = 1'b0; step(6);
    end
    check("pre_rst", 16'(joy_data), 16'h0);
    joy_clk = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_data", 16'(joy_data), 16'h1);
    check("rst_mid_phase", 16'(md_phase), 16'h0);
    joy_clk = 1'b0;
    step(3);
    reset_n = 1'b1;
    last_sel = cyc; m_phase = 0;
    step(20);
    check("rst_after", 16'(joy_data), 16'h1);

    // Exact timeout: phase 2 with select low, then a rise to phase 3
    pad_type = 2'b01;
    sel_set(1'b0); sel_set(1'b1); sel_set(1'b0); sel_set(1'b1); sel_set(1'b0);
    joy_select = 1'b1; last_sel = cyc;
    step(T + 3);
    check("to_hold", 16'(md_phase), 16'h3);
    step(1);
    check("to_drop", 16'(md_phase), 16'h0);
    m_phase = 0;

    // Rising edge coincident with the timeout: 3 -> 0 by increment
    sel_set(1'b0); sel_set(1'b1); sel_set(1'b0); sel_set(1'b1);
    sel_set(1'b0); sel_set(1'b1);
    joy_select = 1'b0;
    step(T + 1);
    joy_select = 1'b1;
    step(2);
    check("coin_r_pre", 16'(md_phase), 16'h3);
    step(1);
    check("coin_rise", 16'(md_phase), 16'h0);
    last_sel = cyc - 3; m_phase = 0;

    // Falling edge coincident with the timeout keeps the phase
    sel_set(1'b0);
    joy_select = 1'b1;
    step(T + 1);
    joy_select = 1'b0;
    step(3);
    check("coin_fall", 16'(md_phase), 16'h1);
    step(T / 2);
    check("coin_clear", 16'(md_phase), 16'h1);
    last_sel = cyc - (T / 2) - 3; m_phase = 1;

    // Randomised pads, select activity and idle gaps
    for (int it = 0; it < 20; it++) begin
      joy1_i = 12'($urandom);
      joy2_i = 12'($urandom);
      pad_type = 2'($urandom);
      for (int k = $urandom_range(0, 4); k > 0; k--) sel_set(~joy_select);
      if ($urandom_range(0, 3) == 0) step(T);
      guard();
      check("rnd_phase", 16'(md_phase), 16'(eff_phase()));
      exp_f = model_frame(joy1_i, joy2_i, pad_type, joy_select, eff_phase());
      read_frame(f, 1'($urandom_range(0, 1)));
      check("rnd_frame", f, exp_f);
      check("rnd_tail", 16'(joy_data), 16'h1);
    end

    // Closed-loop decode of a 6-button pad and a passive pad
    sel_set(1'b1);
    step(T + 50);
    pad_type = 2'b01; joy1_i = 12'hEBF; joy2_i = 12'hFFF;
    d1 = '1; d2 = '1;
    read_frame(f, 1'b0);
    d1[5:0] = dec6(f, P1);
    d2[5:0] = dec6(f, P2);
    sel_set(1'b0);
    read_frame(f, 1'b0);
    d1[7] = f[P1]; d1[6] = f[P1+1];
    sel_set(1'b1); sel_set(1'b0); sel_set(1'b1); sel_set(1'b0);
    read_frame(f, 1'b0);
    six = (f[P1+5:P1+2] == 4'b0000);
    sel_set(1'b1);
    read_frame(f, 1'b0);
    if (six) begin
      d1[8] = f[P1+5]; d1[9] = f[P1+4]; d1[10] = f[P1+3]; d1[11] = f[P1+2];
    end
    check("cl_six", 16'(six), 16'h1);
    check("cl_joy1", 16'(d1), 16'h0EBF);
    check("cl_joy2", 16'(d2), 16'h0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joy_shifter_md_emu.md
Name: joy_shifter_md_emu

Overview:
- Emulates the on-board 16-bit parallel-in/serial-out joystick shifter and the two DB9 pads behind it.
- Acts as the far end of the joystick serial link: it responds to joy_clk, joy_load_n and joy_select, and drives joy_data.
- Each port is either a passive 2-button pad or a Mega Drive 6-button pad with its select-phase counter.
- Used as a closed-loop bench model for the joystick decoder, and as a pad source on boards without the physical shifter.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on joy_clk, joy_load_n and joy_select.
- TIMEOUT_CYCLES, 75000, clk cycles without any joy_select edge before the MD phase returns to 0 (1.5 ms at 50 MHz).
- P1_POS, 2, frame position of the first pad-1 bit.
- P2_POS, 10, frame position of the first pad-2 bit.

Ports:
- clk  in  1  system clock, 64 MHz max.
- reset_n  in  1  asynchronous active-low reset.
- joy_clk  in  1  shift clock from the decoder; asynchronous; rising edge shifts.
- joy_load_n  in  1  parallel load, active low; asynchronous.
- joy_select  in  1  pad select line; asynchronous.
- joy1_i  in  12  pad-1 buttons, MXYZ SACB RLDU, negative logic.
- joy2_i  in  12  pad-2 buttons, same format.
- pad_type  in  2  bit n=1 means pad n+1 is a 6-button MD pad; 0 means passive.
- joy_data  out  1  serial data.
- md_phase  out  2  current MD phase, for the bench.

Behaviour:
- Synchronisers: every async input passes through SYNC_STAGES flops, then one edge-detect flop.
  - Reset values: joy_clk 0, joy_load_n 1, joy_select 1.
  - All logic below uses the synchronised signals.
- Phase counter (2-bit, shared by both pads):
  - Increments, wrapping mod 4, on each synchronised joy_select rising edge.
  - Idle counter (17-bit) clears on any select edge and otherwise counts up, saturating at TIMEOUT_CYCLES.
  - When the idle counter equals TIMEOUT_CYCLES and no edge occurs that cycle, phase <= 0.
  - An edge in the same cycle wins over the timeout: phase increments and the counter clears.
- Pad line values per pad, as 6 lines {U,D,L,R,F1,F2}, with S = synchronised select:
  - Passive pad, any S: U=b0 D=b1 L=b2 R=b3 F1=b4(B) F2=b5(C).
  - MD, S=1, phase 0/1/2: U D L R B C (b0..b5).
  - MD, S=1, phase 3: U=Z(b8) D=Y(b9) L=X(b10) R=M(b11) F1=1 F2=1.
  - MD, S=0, phase 0/1/3: U=b0 D=b1 L=0 R=0 F1=Start(b7) F2=A(b6).
  - MD, S=0, phase 2: U=0 D=0 L=0 R=0 F1=b7 F2=b6.
- Frame (16 bits, positions 0..15):
  - Pad 1 at P1_POS..P1_POS+5 in order F1,F2,R,L,D,U.
  - Pad 2 at P2_POS..P2_POS+5 in the same order.
  - All other positions are 1.
- Shift register (16-bit, sreg[0] drives joy_data):
  - While synchronised joy_load_n=0, sreg reloads every clk from the current frame (transparent load, as a 165).
  - On a joy_clk rising edge while joy_load_n=1, sreg shifts one place toward bit 0 and a 1 enters at bit 15.
  - After 16 or more shifts, joy_data stays at 1.
- Simultaneous events: load low together with a joy_clk edge means load wins and no shift occurs.
- Latency: joy_data changes SYNC_STAGES+1 clk after a joy_clk or joy_load_n transition.
- Reset: reset_n low at any time, including mid-frame, sets sreg to all ones, joy_data=1, phase=0, idle counter=0, and synchronisers to their idle values. Release is synchronous to clk with no spurious edge detection.

Test Plan:
1. Assert reset_n low mid-shift with a pad pressing Up -> joy_data=1 within the same cycle, md_phase=0; after release joy_data stays 1 until the next load.
2. pad_type=00, joy1_i=12'hFFE (Up), one load then 16 joy_clk edges -> position 7 = 0, all other positions = 1.
3. pad_type=01, joy1_i Start pressed (12'hF7F), select low, phase 0, load -> pos2=0, pos4=0, pos5=0, pos3=1, pos6=1, pos7=1.
4. pad_type=01, three select rising edges, select high, X pressed (12'hBFF), load -> pos5=0, pos2=1, pos3=1; md_phase=3.
5. Select held static for TIMEOUT_CYCLES -> md_phase drops 3->0 exactly at the count; a select edge landing on that same cycle instead gives 3->0 by increment and clears the counter.
6. Closed loop with the joystick decoder at 50 MHz, pad_type=01, joy1_i A+Z pressed (12'hEBF), pad 2 passive idle -> decoder joy1_o=12'hEBF and joy2_o=12'hFFF after at most 4 full select periods.
